instr_sequencer: RTL and testbench
==================================

Name: instr_sequencer

Overview:
- Multi-cycle fetch/decode/execute controller for the 32-bit accumulator processor. Generates the program counter, instruction register, accumulator, memory and address-mux strobes from one clock.
- Replaces the separate fetch/exec clocks with a single-clock FSM. Tolerates a variable-latency memory through a ready handshake and aborts on memory timeout.

Parameters:
- OPW, 4, opcode width.
- TIMEOUT, 15, max cycles waiting for mem_ready in any memory state before entering ERROR (1..255).
- CNTW, 16, width of retired-instruction counter.

Ports:
- execlk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-low reset.
- start  input  1  leave IDLE/HALT and begin fetching (level sampled).
- opcode  input  OPW  opcode field from instruction register, valid from the cycle after ldir.
- acc_zero  input  1  accumulator == 0, used by JZ.
- mem_ready  input  1  memory completed current rd/wr this cycle.
- fetch  output  1  address mux select: 1 = PC, 0 = IR operand.
- rd  output  1  memory read strobe.
- wr  output  1  memory write strobe.
- ldir  output  1  load instruction register (1-cycle pulse).
- incpc  output  1  increment PC (1-cycle pulse).
- ldpc  output  1  load PC from IR operand (1-cycle pulse).
- ldacc  output  1  load accumulator from ALU (1-cycle pulse).
- busy  output  1  not in IDLE/HALT/ERROR.
- halted  output  1  in HALT.
- error  output  1  in ERROR (timeout) or illegal opcode seen (sticky).
- instr_count  output  CNTW  retired instructions, wraps at 2^CNTW.

Behaviour:
- All outputs registered (Moore, decoded from next state). On rst=0 at a clock edge: state=IDLE, all strobes 0, fetch=0, busy=0, halted=0, error=0, instr_count=0.
- Reset mid-operation abandons the instruction with no further strobes; the reset cycle dominates all other inputs.
- Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JMP, 9 JZ, F HLT. A–E are illegal: executed as NOP, error set sticky, FSM continues.
- States and transitions:
  - IDLE: start=1 -> FETCH.
  - FETCH: fetch=1, rd=1 held. On mem_ready=1 -> LOADIR.
  - LOADIR: ldir=1, incpc=1 for exactly one cycle -> DECODE.
  - DECODE: no strobes.
    - NOP/illegal -> RETIRE.
    - LDA/ADD/SUB/AND/OR/XOR -> OPRD.
    - STA -> OPWR.
    - JMP -> BRANCH.
    - JZ: acc_zero=1 -> BRANCH, else RETIRE.
    - HLT -> HALT.
  - OPRD: fetch=0, rd=1 held. On mem_ready -> EXEC.
  - OPWR: fetch=0, wr=1 held. On mem_ready -> RETIRE.
  - EXEC: ldacc=1 one cycle -> RETIRE.
  - BRANCH: ldpc=1 one cycle -> RETIRE.
  - RETIRE: instr_count+1 -> FETCH.
  - HALT: halted=1. instr_count increments once on entry (HLT counts as retired). start=1 -> FETCH.
  - ERROR: error=1, all strobes 0. Exits only via rst.
- Timeout: a wait counter clears on entry to FETCH/OPRD/OPWR and increments each cycle mem_ready=0. When it reaches TIMEOUT with mem_ready still 0 -> ERROR. mem_ready=1 on the same cycle the counter hits TIMEOUT completes normally (ready wins).
- mem_ready outside FETCH/OPRD/OPWR is ignored.
- rd and wr are never both 1. ldpc and incpc are never both 1.
- Latency with mem_ready tied 1:
  - ALU/LDA: 6 cycles (FETCH, LOADIR, DECODE, OPRD, EXEC, RETIRE).
  - STA: 5 cycles.
  - NOP, JZ not taken: 4 cycles.
  - JMP, JZ taken: 5 cycles.
- start is ignored while busy=1.

Test Plan:
- Reset/idle: hold rst=0 for 2 cycles with start=1 -> all outputs 0, instr_count=0. Release with start=1 -> fetch=1, rd=1 in the first cycle after FETCH is entered.
- ADD stream: mem_ready=1, opcode=3 ×3 -> per instruction ldacc pulses exactly once, 6 cycles apart; incpc 3 pulses; instr_count=3.
- Wait states: STA with mem_ready low 4 cycles in OPWR -> wr held 5 cycles, single RETIRE, error=0.
- Branches: JZ with acc_zero=1 -> one ldpc pulse, no ldacc. JZ with acc_zero=0 -> no ldpc, 4-cycle instruction.
- Timeout: TIMEOUT=3, mem_ready=0 in FETCH -> ERROR after 3 wait cycles, error=1, strobes 0 until rst. Boundary variant: mem_ready=1 exactly on the 3rd cycle -> no error.
- Illegal/HLT: opcode=B -> error=1, FSM continues. Then opcode=F -> halted=1, busy=0, instr_count=2. start=1 -> resumes FETCH.

Source files
------------

// File: rtl/instr_sequencer.sv
// Single-clock fetch/decode/execute controller for the 32-bit accumulator processor.
// Moore outputs are registered from the next state; memory phases wait on mem_ready_i with a timeout.
module instr_sequencer #(
  parameter int unsigned OPW     = 4,
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNTW    = 16
) (
  input  logic            execlk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic [OPW-1:0]  opcode_i,
  input  logic            acc_zero_i,
  input  logic            mem_ready_i,
  output logic            fetch_o,
  output logic            rd_o,
  output logic            wr_o,
  output logic            ldir_o,
  output logic            incpc_o,
  output logic            ldpc_o,
  output logic            ldacc_o,
  output logic            busy_o,
  output logic            halted_o,
  output logic            error_o,
  output logic [CNTW-1:0] instr_count_o
);

  localparam int unsigned WAITW = 8;

  localparam logic [OPW-1:0] OP_NOP = OPW'(0);
  localparam logic [OPW-1:0] OP_LDA = OPW'(1);
  localparam logic [OPW-1:0] OP_STA = OPW'(2);
  localparam logic [OPW-1:0] OP_ADD = OPW'(3);
  localparam logic [OPW-1:0] OP_SUB = OPW'(4);
  localparam logic [OPW-1:0] OP_AND = OPW'(5);
  localparam logic [OPW-1:0] OP_OR  = OPW'(6);
  localparam logic [OPW-1:0] OP_XOR = OPW'(7);
  localparam logic [OPW-1:0] OP_JMP = OPW'(8);
  localparam logic [OPW-1:0] OP_JZ  = OPW'(9);
  localparam logic [OPW-1:0] OP_HLT = OPW'(15);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_LOADIR, S_DECODE, S_OPRD, S_OPWR,
    S_EXEC, S_BRANCH, S_RETIRE, S_HALT, S_ERROR
  } state_e;

  state_e             state_q, state_d;
  logic [WAITW-1:0]   wait_q, wait_d;
  logic               illegal_c;
  logic               mem_state_c;
  logic               timeout_c;

  logic               fetch_q, rd_q, wr_q, ldir_q, incpc_q, ldpc_q, ldacc_q;
  logic               busy_q, halted_q, error_q;
  logic [CNTW-1:0]    count_q;

  // Next state and wait-counter; a timeout overrides the normal transition, ready wins over timeout.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    illegal_c   = 1'b0;
    mem_state_c = (state_q == S_FETCH) || (state_q == S_OPRD) || (state_q == S_OPWR);
    timeout_c   = mem_state_c && !mem_ready_i && (wait_q == WAITW'(TIMEOUT - 1));
    case (state_q)
      S_IDLE:   if (start_i) state_d = S_FETCH;
      S_FETCH:  if (mem_ready_i) state_d = S_LOADIR;
      S_LOADIR: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode_i)
          OP_NOP:                                       state_d = S_RETIRE;
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: state_d = S_OPRD;
          OP_STA:                                       state_d = S_OPWR;
          OP_JMP:                                       state_d = S_BRANCH;
          OP_JZ:                                        state_d = acc_zero_i ? S_BRANCH : S_RETIRE;
          OP_HLT:                                       state_d = S_HALT;
          default: begin
            illegal_c = 1'b1;
            state_d   = S_RETIRE;
          end
        endcase
      end
      S_OPRD:   if (mem_ready_i) state_d = S_EXEC;
      S_OPWR:   if (mem_ready_i) state_d = S_RETIRE;
      S_EXEC:   state_d = S_RETIRE;
      S_BRANCH: state_d = S_RETIRE;
      S_RETIRE: state_d = S_FETCH;
      S_HALT:   if (start_i) state_d = S_FETCH;
      S_ERROR:  state_d = S_ERROR;
      default:  state_d = S_IDLE;
    endcase
    if (timeout_c) state_d = S_ERROR;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (mem_state_c && !mem_ready_i) begin
      wait_d = wait_q + WAITW'(1);
    end
  end

  // State, wait counter and Moore outputs decoded from the next state.
  always_ff @(posedge execlk_i) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      fetch_q  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ldir_q   <= 1'b0;
      incpc_q  <= 1'b0;
      ldpc_q   <= 1'b0;
      ldacc_q  <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
      error_q  <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wait_q   <= wait_d;
      fetch_q  <= (state_d == S_FETCH);
      rd_q     <= (state_d == S_FETCH) || (state_d == S_OPRD);
      wr_q     <= (state_d == S_OPWR);
      ldir_q   <= (state_d == S_LOADIR);
      incpc_q  <= (state_d == S_LOADIR);
      ldpc_q   <= (state_d == S_BRANCH);
      ldacc_q  <= (state_d == S_EXEC);
      busy_q   <= !((state_d == S_IDLE) || (state_d == S_HALT) || (state_d == S_ERROR));
      halted_q <= (state_d == S_HALT);
      error_q  <= error_q || illegal_c || (state_d == S_ERROR);
      if ((state_d == S_RETIRE) || ((state_d == S_HALT) && (state_q != S_HALT))) begin
        count_q <= count_q + CNTW'(1);
      end
    end
  end

  assign fetch_o       = fetch_q;
  assign rd_o          = rd_q;
  assign wr_o          = wr_q;
  assign ldir_o        = ldir_q;
  assign incpc_o       = incpc_q;
  assign ldpc_o        = ldpc_q;
  assign ldacc_o       = ldacc_q;
  assign busy_o        = busy_q;
  assign halted_o      = halted_q;
  assign error_o       = error_q;
  assign instr_count_o = count_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: per-instruction transaction model (latency, pulse and strobe counts)
// on a default instance, plus a TIMEOUT=3 instance for the memory timeout boundary.
module tb_instr_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, acc_zero, mem_ready;
  logic [3:0]  opcode;
  logic        fetch, rd, wr, ldir, incpc, ldpc, ldacc, busy, halted, error;
  logic [15:0] icount;

  logic        t_rst_n, t_start, t_acc_zero, t_ready;
  logic [3:0]  t_op;
  logic        t_fetch, t_rd, t_wr, t_ldir, t_incpc, t_ldpc, t_ldacc, t_busy, t_halted, t_error;
  logic [15:0] t_icount;

  instr_sequencer dut (
    .execlk_i(clk), .rst_ni(rst_n), .start_i(start), .opcode_i(opcode),
    .acc_zero_i(acc_zero), .mem_ready_i(mem_ready),
    .fetch_o(fetch), .rd_o(rd), .wr_o(wr), .ldir_o(ldir), .incpc_o(incpc),
    .ldpc_o(ldpc), .ldacc_o(ldacc), .busy_o(busy), .halted_o(halted),
    .error_o(error), .instr_count_o(icount)
  );

  instr_sequencer #(.OPW(4), .TIMEOUT(3), .CNTW(16)) dut_t (
    .execlk_i(clk), .rst_ni(t_rst_n), .start_i(t_start), .opcode_i(t_op),
    .acc_zero_i(t_acc_zero), .mem_ready_i(t_ready),
    .fetch_o(t_fetch), .rd_o(t_rd), .wr_o(t_wr), .ldir_o(t_ldir), .incpc_o(t_incpc),
    .ldpc_o(t_ldpc), .ldacc_o(t_ldacc), .busy_o(t_busy), .halted_o(t_halted),
    .error_o(t_error), .instr_count_o(t_icount)
  );

  int n_cmp = 0;
  int n_mis = 0;
  int exp_count = 0;
  bit exp_err = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  // Runs one instruction starting in its FETCH cycle; memory answers after wf / wm wait cycles.
  task automatic run_instr(input logic [3:0] op, input logic az, input int wf, input int wm,
                           input bit rand_start);
    int cyc = 0, ph = 0, lat;
    int n_ldacc = 0, n_ldpc = 0, n_incpc = 0, n_ldir = 0;
    int n_rd = 0, n_wr = 0, n_fetch = 0, n_clash = 0, n_idle = 0;
    bit done = 1'b0, alu, sta, br, ill;
    logic [15:0] c0;
    c0 = icount;
    opcode = op;
    acc_zero = az;
    while (!done && cyc < 200) begin
      if (rand_start) start = 1'($urandom);
      if (rd || wr) begin
        mem_ready = (ph == (fetch ? wf : wm));
        ph++;
      end else begin
        mem_ready = 1'($urandom);
        ph = 0;
      end
      if (ldacc) n_ldacc++;
      if (ldpc) n_ldpc++;
      if (incpc) n_incpc++;
      if (ldir) n_ldir++;
      if (rd) n_rd++;
      if (wr) n_wr++;
      if (fetch) n_fetch++;
      if ((rd && wr) || (ldpc && incpc)) n_clash++;
      if (!busy) n_idle++;
      cyc++;
      done = (icount != c0);
      @(negedge clk);
    end
    alu = (op == 4'd1) || ((op >= 4'd3) && (op <= 4'd7));
    sta = (op == 4'd2);
    br  = (op == 4'd8) || ((op == 4'd9) && az);
    ill = (op >= 4'd10) && (op <= 4'd14);
    lat = 4 + wf + (alu ? 2 + wm : 0) + (sta ? 1 + wm : 0) + (br ? 1 : 0);
    exp_count++;
    exp_err = exp_err | ill;
    chk($sformatf("op%0h_latency", op), 32'(cyc), 32'(lat));
    chk($sformatf("op%0h_ldacc", op), 32'(n_ldacc), 32'(alu));
    chk($sformatf("op%0h_ldpc", op), 32'(n_ldpc), 32'(br));
    chk($sformatf("op%0h_incpc", op), 32'(n_incpc), 32'd1);
    chk($sformatf("op%0h_ldir", op), 32'(n_ldir), 32'd1);
    chk($sformatf("op%0h_rd_cycles", op), 32'(n_rd), 32'(1 + wf + (alu ? 1 + wm : 0)));
    chk($sformatf("op%0h_wr_cycles", op), 32'(n_wr), 32'(sta ? 1 + wm : 0));
    chk($sformatf("op%0h_fetch_cycles", op), 32'(n_fetch), 32'(1 + wf));
    chk($sformatf("op%0h_exclusive", op), 32'(n_clash), 32'd0);
    chk($sformatf("op%0h_busy", op), 32'(n_idle), 32'd0);
    chk($sformatf("op%0h_count", op), 32'(icount), 32'(exp_count));
    chk($sformatf("op%0h_error", op), 32'(error), 32'(exp_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    int cyc;
    rst_n = 1'b0; start = 1'b1; mem_ready = 1'b0; opcode = 4'd0; acc_zero = 1'b0;
    t_rst_n = 1'b0; t_start = 1'b0; t_ready = 1'b0; t_op = 4'd0; t_acc_zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'({fetch, rd, wr, ldir, incpc, ldpc, ldacc, busy, halted, error}), 32'd0);
    chk("reset_count", 32'(icount), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("start_fetch", 32'({fetch, rd, busy}), 32'b111);
    start = 1'b0;

    repeat (3) run_instr(4'd3, 1'b0, 0, 0, 1'b0);
    chk("add_stream_count", 32'(icount), 32'd3);
    run_instr(4'd2, 1'b0, 0, 4, 1'b0);
    run_instr(4'd9, 1'b1, 0, 0, 1'b0);
    run_instr(4'd9, 1'b0, 0, 0, 1'b0);
    run_instr(4'd8, 1'b0, 2, 0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) op = 4'($urandom_range(10, 14));
      else op = 4'($urandom_range(0, 9));
      run_instr(op, 1'($urandom), int'($urandom_range(0, 5)), int'($urandom_range(0, 5)), 1'b1);
    end
    start = 1'b0;

    // Reset while FETCH waits on memory, with every other input trying to advance it.
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; mem_ready = 1'b1; start = 1'b1;
    @(negedge clk);
    chk("midop_reset_outputs", 32'({fetch, rd, wr, ldir, incpc, ldpc, ldacc, busy, halted, error}), 32'd0);
    chk("midop_reset_count", 32'(icount), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_count = 0;
    exp_err = 1'b0;
    run_instr(4'hB, 1'b0, 0, 0, 1'b0);

    opcode = 4'hF; mem_ready = 1'b1;
    cyc = 0;
    while (!halted && cyc < 20) begin
      cyc++;
      @(negedge clk);
    end
    chk("hlt_cycles", 32'(cyc), 32'd3);
    chk("hlt_state", 32'({halted, busy, error}), 32'b101);
    chk("hlt_count", 32'(icount), 32'd2);
    repeat (2) @(negedge clk);
    chk("hlt_count_stable", 32'({halted, icount}), 32'({1'b1, 16'd2}));
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("hlt_resume", 32'({fetch, rd, halted, busy}), 32'b1101);
    exp_count = 2;
    exp_err = 1'b1;
    run_instr(4'd1, 1'b0, 1, 1, 1'b0);

    // TIMEOUT=3 instance: three silent FETCH cycles abort.
    t_rst_n = 1'b1; t_start = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    chk("to_fetch_c1", 32'({t_fetch, t_rd, t_error}), 32'b110);
    @(negedge clk);
    @(negedge clk);
    chk("to_fetch_c3", 32'({t_rd, t_error}), 32'b10);
    @(negedge clk);
    chk("to_error", 32'({t_error, t_busy, t_halted}), 32'b100);
    chk("to_strobes", 32'({t_fetch, t_rd, t_wr, t_ldir, t_incpc, t_ldpc, t_ldacc}), 32'd0);
    t_start = 1'b1; t_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("to_error_sticky", 32'({t_error, t_fetch, t_rd, t_wr, t_ldir, t_incpc, t_ldpc, t_ldacc}), 32'h80);
    t_rst_n = 1'b0; t_ready = 1'b0;
    @(negedge clk);
    chk("to_reset_clears", 32'({t_error, t_busy}), 32'd0);
    t_rst_n = 1'b1;
    @(negedge clk);
    t_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    t_ready = 1'b1;
    @(negedge clk);
    chk("to_boundary_ready", 32'({t_ldir, t_incpc, t_error, t_busy}), 32'b1101);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
